// File: rtl/login_pkg.sv
// login_pkg: shared state encoding, BCD limits and default passwords for the login sequencer.
package login_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_GUEST,
    S_ENTRY,
    S_CHECK,
    S_FAIL,
    S_LOCK,
    S_GRANT
  } state_t;
  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [15:0] DEF_PASS0 = 16'h1234;
  localparam logic [15:0] DEF_PASS1 = 16'h5678;
  localparam int          DIGITS    = 4;
  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg: 4-digit BCD shift accumulator; non-BCD strobes are dropped and the count saturates when full.
module bcd_entry_reg
  import login_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [3:0]  i_digit,
  input  logic        i_valid,
  output logic [15:0] o_value,
  output logic [2:0]  o_count,
  output logic        o_full,
  output logic        o_last
);
  logic [15:0] r_value;
  logic [2:0]  r_count;
  logic        w_take;
  assign o_full  = r_count == 3'(DIGITS);
  assign w_take  = i_en && i_valid && is_bcd(i_digit) && !o_full;
  assign o_last  = w_take && r_count == 3'(DIGITS - 1);
  assign o_value = r_value;
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_value <= '0;
      r_count <= '0;
    end else if (w_take) begin
      r_value <= {r_value[11:0], i_digit};
      r_count <= r_count + 3'd1;
    end
  end
endmodule

// File: rtl/login_sequencer.sv
// login_sequencer: guest/password session FSM with two stored users, failed-attempt counting and timed lockout.
module login_sequencer
  import login_pkg::*;
#(
  parameter logic [15:0] PASS0       = DEF_PASS0,
  parameter logic [15:0] PASS1       = DEF_PASS1,
  parameter int          MAX_TRIES   = 3,
  parameter int          LOCK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pw_mode,
  input  logic       start,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       busy,
  output logic [2:0] digit_count,
  output logic       access_granted,
  output logic       user_id,
  output logic       guest,
  output logic       bad_pw,
  output logic       locked,
  output logic [1:0] fail_count
);
  localparam int CW = $clog2(LOCK_CYCLES);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_lock_cnt, w_lock_cnt;
  logic            r_busy, r_granted, r_user, r_guest, r_bad, r_locked;
  logic [1:0]      r_fail, w_fail, w_fail_inc;
  logic            w_busy, w_granted, w_user, w_guest, w_bad, w_locked;
  logic [15:0]     w_value;
  logic            w_full, w_last, w_clr;
  logic            w_match0, w_match1, w_match, w_lock_done;
  assign w_match0    = w_value == PASS0;
  assign w_match1    = w_value == PASS1;
  assign w_match     = w_match0 || w_match1;
  assign w_lock_done = r_lock_cnt == '0;
  assign w_fail_inc  = r_fail + 2'd1;
  // Digits are wiped when a password session opens, after a miss, and when lockout expires.
  assign w_clr = (r_state == S_IDLE && start && pw_mode) ||
                 (r_state == S_CHECK && !w_match) ||
                 (r_state == S_LOCK && w_lock_done);
  bcd_entry_reg u_entry (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (r_state == S_ENTRY),
    .i_digit (digit_in),
    .i_valid (digit_valid),
    .o_value (w_value),
    .o_count (digit_count),
    .o_full  (w_full),
    .o_last  (w_last)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lock_cnt <= '0;
      r_busy     <= 1'b0;
      r_granted  <= 1'b0;
      r_user     <= 1'b0;
      r_guest    <= 1'b0;
      r_bad      <= 1'b0;
      r_locked   <= 1'b0;
      r_fail     <= '0;
    end else begin
      r_state    <= w_next;
      r_lock_cnt <= w_lock_cnt;
      r_busy     <= w_busy;
      r_granted  <= w_granted;
      r_user     <= w_user;
      r_guest    <= w_guest;
      r_bad      <= w_bad;
      r_locked   <= w_locked;
      r_fail     <= w_fail;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? (pw_mode ? S_ENTRY : S_GUEST) : S_IDLE;
      S_ENTRY: w_next = w_last ? S_CHECK : S_ENTRY;
      S_CHECK: w_next = w_match ? S_GRANT : (w_fail_inc == 2'(MAX_TRIES)) ? S_LOCK : S_FAIL;
      S_FAIL:  w_next = S_ENTRY;
      S_LOCK:  w_next = w_lock_done ? S_ENTRY : S_LOCK;
      default: w_next = r_state;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_busy     = w_next inside {S_ENTRY, S_CHECK, S_FAIL, S_LOCK};
    w_granted  = w_next == S_GRANT;
    w_guest    = w_next == S_GUEST;
    w_locked   = w_next == S_LOCK;
    w_bad      = r_state == S_CHECK && !w_match;
    w_user     = (r_state == S_CHECK) ? (!w_match0 && w_match1) : r_user;
    w_fail     = (r_state == S_CHECK) ? (w_match ? 2'd0 : w_fail_inc) :
                 (r_state == S_LOCK && w_lock_done) ? 2'd0 : r_fail;
    w_lock_cnt = (r_state == S_CHECK) ? CW'(LOCK_CYCLES - 1) :
                 (r_state == S_LOCK && !w_lock_done) ? r_lock_cnt - CW'(1) : r_lock_cnt;
  end
  assign busy           = r_busy;
  assign access_granted = r_granted;
  assign user_id        = r_user;
  assign guest          = r_guest;
  assign bad_pw         = r_bad;
  assign locked         = r_locked;
  assign fail_count     = r_fail;
endmodule
